// File: rtl/actuator_cycle_ctrl.sv
// Endurance-test sequencer for a linear actuator.
// Runs extend/retract cycles between limit switches with a dead time at each reversal.
module actuator_cycle_ctrl #(
  parameter int CYCLES   = 100,
  parameter int TIMEOUT  = 50000000,
  parameter int DEADTIME = 1000000,
  parameter int COUNT_W  = 16,
  parameter int TIMER_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_p,
  input  logic               stop_p,
  input  logic               ext_limit,
  input  logic               ret_limit,
  output logic               motor_ext,
  output logic               motor_ret,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [COUNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    EXTEND,
    DWELL_E,
    RETRACT,
    DWELL_R,
    DONE,
    FAULT
  } state_t;

  localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DT_LAST = TIMER_W'(DEADTIME - 1);
  localparam logic [COUNT_W-1:0] CYC     = COUNT_W'(CYCLES);
  localparam logic               RUN_ON  = (CYCLES == 0);

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic [COUNT_W-1:0]   count_nxt;
  logic [COUNT_W-1:0]   count_inc;
  logic                 both_lim;

  assign both_lim  = ext_limit & ret_limit;
  assign count_inc = cycle_count + COUNT_W'(1);

  // State, timer and cycle counter registers; async reset drops the motors at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      cycle_count <= count_nxt;
    end
  end

  // Next-state logic: stop > both-limits fault > limit transition > timer expiry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = cycle_count;
    unique case (state)
      IDLE: begin
        if (start_p && !stop_p) begin
          state_nxt = EXTEND;
          timer_nxt = '0;
          count_nxt = '0;
        end
      end
      EXTEND: begin
        if (stop_p) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (both_lim) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else if (ext_limit) begin
          state_nxt = DWELL_E;
          timer_nxt = '0;
        end else if (timer == TO_LAST) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DWELL_E: begin
        if (stop_p) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (both_lim) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else if (timer == DT_LAST) begin
          state_nxt = RETRACT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      RETRACT: begin
        if (stop_p) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (both_lim) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else if (ret_limit) begin
          count_nxt = count_inc;
          timer_nxt = '0;
          if (!RUN_ON && count_inc == CYC) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DWELL_R;
          end
        end else if (timer == TO_LAST) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DWELL_R: begin
        if (stop_p) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (both_lim) begin
          state_nxt = FAULT;
          timer_nxt = '0;
        end else if (timer == DT_LAST) begin
          state_nxt = EXTEND;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DONE: begin
        if (stop_p) begin
          state_nxt = IDLE;
        end else if (start_p) begin
          state_nxt = EXTEND;
          timer_nxt = '0;
          count_nxt = '0;
        end
      end
      FAULT: begin
        if (stop_p) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  // Outputs decoded straight from the registered state.
  always_comb begin
    motor_ext = (state == EXTEND);
    motor_ret = (state == RETRACT);
    busy      = (state == EXTEND) || (state == DWELL_E) ||
                (state == RETRACT) || (state == DWELL_R);
    done      = (state == DONE);
    fault     = (state == FAULT);
  end

endmodule

// File: tb/tb_actuator_cycle_ctrl.sv
// Directed bench for actuator_cycle_ctrl.
// A small actuator model reaches each limit 5 cycles after its motor turns on.
module tb_actuator_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_p, stop_p, ext_limit, ret_limit;
  logic        motor_ext, motor_ret, busy, done, fault;
  logic [15:0] cycle_count;

  logic        start0, stop0, el0, rl0;
  logic        me0, mr0, busy0, done0, fault0;
  logic [15:0] cnt0;

  int total = 0;
  int bad   = 0;
  logic m_en  = 1'b0;
  logic m_en0 = 1'b0;
  int mc  = 0;
  int mc0 = 0;

  always #5 clk = ~clk;

  actuator_cycle_ctrl #(
    .CYCLES(3), .TIMEOUT(16), .DEADTIME(4), .COUNT_W(16), .TIMER_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start_p(start_p), .stop_p(stop_p),
    .ext_limit(ext_limit), .ret_limit(ret_limit),
    .motor_ext(motor_ext), .motor_ret(motor_ret), .busy(busy),
    .done(done), .fault(fault), .cycle_count(cycle_count)
  );

  actuator_cycle_ctrl #(
    .CYCLES(0), .TIMEOUT(16), .DEADTIME(4), .COUNT_W(16), .TIMER_W(32)
  ) dut0 (
    .clk(clk), .reset(reset), .start_p(start0), .stop_p(stop0),
    .ext_limit(el0), .ret_limit(rl0),
    .motor_ext(me0), .motor_ret(mr0), .busy(busy0),
    .done(done0), .fault(fault0), .cycle_count(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_tick(input logic me, input logic mr, inout int cnt,
                            inout logic el, inout logic rl);
    if (me) begin
      rl = 1'b0;
      cnt++;
      if (cnt >= 5) el = 1'b1;
    end else if (mr) begin
      el = 1'b0;
      cnt++;
      if (cnt >= 5) rl = 1'b1;
    end else begin
      cnt = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (m_en)  model_tick(motor_ext, motor_ret, mc, ext_limit, ret_limit);
    if (m_en0) model_tick(me0, mr0, mc0, el0, rl0);
  endtask

  initial begin
    int off, run, ncyc, n, hi;
    logic [15:0] last;
    logic seen;

    reset = 1'b1;
    start_p = 0; stop_p = 0; ext_limit = 0; ret_limit = 0;
    start0 = 0; stop0 = 0; el0 = 0; rl0 = 0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mext", motor_ext, 0);
    chk("rst_mret", motor_ret, 0);
    chk("rst_cnt", cycle_count, 0);

    // 1. nominal run of 3 cycles
    ret_limit = 1; ext_limit = 0; mc = 0; m_en = 1;
    off = 0; run = 0; ncyc = 0; last = 0;
    start_p = 1;
    for (n = 0; n < 300 && !done; n++) begin
      step();
      start_p = 0;
      if (motor_ext && motor_ret) chk("both_mot", 1, 0);
      if (motor_ext || motor_ret) begin
        if (off > 0) begin
          chk("dead", off, 4);
          off = 0;
        end
        run++;
      end else begin
        if (run > 0) begin
          chk("run", run, 5);
          run = 0;
        end
        if (busy) off++;
      end
      if (cycle_count != last) begin
        ncyc++;
        chk("cnt_step", cycle_count, ncyc);
        last = cycle_count;
      end
    end
    chk("nom_cycles", ncyc, 3);
    chk("nom_done", done, 1);
    chk("nom_busy", busy, 0);
    chk("nom_cnt", cycle_count, 3);

    // 5a. restart from DONE
    start_p = 1;
    step();
    start_p = 0;
    chk("rs_cnt", cycle_count, 0);
    chk("rs_mext", motor_ext, 1);
    chk("rs_done", done, 0);
    stop_p = 1;
    step();
    stop_p = 0;
    chk("rs_stop", busy, 0);

    // 2. timeout in EXTEND
    m_en = 0; ext_limit = 0; ret_limit = 0;
    hi = 0;
    start_p = 1;
    for (n = 0; n < 40 && !fault; n++) begin
      step();
      start_p = 0;
      if (motor_ext) hi++;
    end
    chk("to_hi", hi, 16);
    chk("to_fault", fault, 1);
    chk("to_mext", motor_ext, 0);
    chk("to_cnt", cycle_count, 0);
    start_p = 1;
    step();
    start_p = 0;
    chk("to_start_ign", fault, 1);
    chk("to_start_mot", motor_ext, 0);
    stop_p = 1;
    step();
    stop_p = 0;
    chk("to_clr", fault, 0);
    chk("to_idle", busy, 0);

    // 3. both-limits sensor fault during RETRACT
    ext_limit = 0; ret_limit = 1; mc = 0; m_en = 1;
    start_p = 1;
    for (n = 0; n < 100 && !motor_ret; n++) begin
      step();
      start_p = 0;
    end
    chk("sf_reached", motor_ret, 1);
    m_en = 0;
    ext_limit = 1; ret_limit = 1;
    step();
    chk("sf_fault", fault, 1);
    chk("sf_mret", motor_ret, 0);
    chk("sf_cnt", cycle_count, 0);
    ext_limit = 0; ret_limit = 0;
    stop_p = 1;
    step();
    stop_p = 0;

    // 4. stop during DWELL_R after cycle 1
    ext_limit = 0; ret_limit = 1; mc = 0; m_en = 1;
    seen = 0;
    start_p = 1;
    for (n = 0; n < 100 && !seen; n++) begin
      step();
      start_p = 0;
      if (cycle_count == 1 && busy && !motor_ext && !motor_ret) seen = 1;
    end
    chk("st_dwellr", seen, 1);
    stop_p = 1;
    step();
    stop_p = 0;
    m_en = 0;
    chk("st_busy", busy, 0);
    chk("st_done", done, 0);
    chk("st_cnt", cycle_count, 1);
    start_p = 1; stop_p = 1;
    step();
    start_p = 0; stop_p = 0;
    chk("ss_busy", busy, 0);
    chk("ss_mext", motor_ext, 0);
    chk("ss_cnt", cycle_count, 1);

    // 5b. CYCLES=0 runs on without done
    el0 = 0; rl0 = 1; mc0 = 0; m_en0 = 1;
    seen = 0;
    start0 = 1;
    for (n = 0; n < 400 && cnt0 != 5; n++) begin
      step();
      start0 = 0;
      if (done0) seen = 1;
    end
    chk("c0_cnt", cnt0, 5);
    chk("c0_done", seen, 0);
    chk("c0_busy", busy0, 1);
    stop0 = 1;
    step();
    stop0 = 0;
    m_en0 = 0;
    chk("c0_stop", busy0, 0);

    // 6. async reset mid-EXTEND
    ext_limit = 0; ret_limit = 0;
    start_p = 1;
    step();
    start_p = 0;
    step(); step();
    chk("ar_pre", motor_ext, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_mext", motor_ext, 0);
    chk("ar_busy", busy, 0);
    chk("ar_fault", fault, 0);
    chk("ar_cnt", cycle_count, 0);
    step();
    reset = 1'b0;
    step();
    chk("ar_idle", busy, 0);
    start_p = 1;
    step();
    start_p = 0;
    chk("ar_restart", motor_ext, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/actuator_cycle_ctrl.md
Name: actuator_cycle_ctrl

Overview:
Sequencer for the linear actuator endurance test. It drives the actuator back and forth between its extend and retract limit switches, with a dead-time pause at each reversal, and counts completed cycles. It stops after a programmed number of cycles, or on a stop command, timeout or sensor fault. start_p and stop_p are single-cycle pulses from the team's rising-edge blip generators; the limit inputs are already synchronized to clk.

Parameters:
CYCLES, 100, number of full extend+retract cycles to run; 0 = run until stopped
TIMEOUT, 50000000, max clk cycles allowed in EXTEND or RETRACT before fault
DEADTIME, 1000000, clk cycles motors stay off between direction reversals (>=1)
COUNT_W, 16, width of cycle_count
TIMER_W, 32, width of internal timer; must hold max(TIMEOUT, DEADTIME)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_p  in  1  one-cycle start pulse
stop_p  in  1  one-cycle stop pulse
ext_limit  in  1  extend limit switch, 1 = at limit (synchronized level)
ret_limit  in  1  retract limit switch, 1 = at limit (synchronized level)
motor_ext  out  1  drive actuator outward
motor_ret  out  1  drive actuator inward
busy  out  1  sequence running (EXTEND/DWELL_E/RETRACT/DWELL_R)
done  out  1  programmed cycle count reached
fault  out  1  timeout or both-limits sensor fault
cycle_count  out  COUNT_W  completed cycles since last start

Behaviour:
- Reset (async): state=IDLE, timer=0. All outputs 0, cycle_count=0.
- Output timing: all outputs are registered or decoded from the registered state. They change on the same edge as the state transition, one clk after the causing input is sampled.
- motor_ext and motor_ret are never 1 simultaneously. Both are 0 in every state except EXTEND (ext=1) and RETRACT (ret=1).
- IDLE: start_p -> EXTEND, clear cycle_count, timer=0.
- EXTEND:
  - ext_limit=1 -> DWELL_E, timer=0.
  - Otherwise, when timer==TIMEOUT-1 -> FAULT.
  - Otherwise timer+1.
- DWELL_E: timer==DEADTIME-1 -> RETRACT, timer=0; else timer+1.
- RETRACT:
  - ret_limit=1 -> cycle_count+1 (wraps modulo 2^COUNT_W).
  - After the increment: if CYCLES!=0 and the new count==CYCLES -> DONE; else DWELL_R. timer=0 in both cases.
  - Timeout handling is the same as in EXTEND.
- DWELL_R: timer==DEADTIME-1 -> EXTEND, timer=0; else timer+1.
- DONE:
  - done=1, motors off, cycle_count held.
  - start_p -> EXTEND with count cleared.
  - stop_p -> IDLE.
- FAULT:
  - fault=1, motors off, cycle_count held.
  - Only stop_p (-> IDLE, fault cleared) or reset leaves FAULT; start_p is ignored.
- Sensor fault: ext_limit=1 and ret_limit=1 in the same cycle while in any busy state -> FAULT. This has priority over the limit transitions.
- stop_p in any busy state -> IDLE next edge, motors off, count retained.
- Priority in busy states: stop_p > both-limits fault > limit transition > timeout.
- start_p and stop_p in the same cycle: stop wins. In IDLE, that combination stays in IDLE.
- start_p while busy is ignored.
- Limit already active on entry: EXTEND with ext_limit=1 leaves after exactly one cycle with the motor on; RETRACT behaves the same way with ret_limit.
- busy=1 exactly in EXTEND, DWELL_E, RETRACT and DWELL_R.
- Reset asserted mid-operation: motors drop asynchronously, without waiting for clk.

Test Plan:
(Bench parameters: CYCLES=3, TIMEOUT=16, DEADTIME=4.)
1. Nominal run: start_p with ret_limit=1; bench model raises ext_limit 5 cycles after motor_ext, ret_limit 5 cycles after motor_ret -> three cycles observed; motors off for exactly 4 cycles at each reversal; cycle_count 1,2,3; done=1, busy=0, cycle_count=3.
2. Timeout: start_p, ext_limit never asserts -> motor_ext high exactly 16 cycles, then fault=1, motors 0, cycle_count=0. start_p ignored. stop_p -> IDLE, fault=0.
3. Sensor fault: during RETRACT force ext_limit=ret_limit=1 -> next edge FAULT, cycle_count unchanged, motor_ret=0.
4. Stop mid-run: stop_p during DWELL_R after cycle 1 -> IDLE next edge, cycle_count=1, busy=0, done=0. Also, start_p and stop_p together in IDLE -> remains IDLE.
5. Restart from DONE: after scenario 1, start_p -> cycle_count=0, motor_ext=1 next cycle. CYCLES=0 build runs 5 cycles with done never asserted.
6. Async reset mid-EXTEND: assert reset between clk edges -> motor_ext=0 immediately; all outputs 0; after release, state is IDLE.
